// File: rtl/regex_fetch_unit_if.sv
// Request, memory and fetched-instruction signal bundle for regex_fetch_unit.
// slave = fetch unit side, master = surrounding logic (request source, memory, consumer).
interface regex_fetch_unit_if #(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  localparam int NCC = 2**CC_ID_BITS;

  logic                         input_pc_valid;
  logic                         input_pc_ready;
  logic [PC_WIDTH-1:0]          input_pc;
  logic [CC_ID_BITS-1:0]        input_cc_id;
  logic [NCC-1:0]               flush_cc;

  logic                         memory_valid;
  logic                         memory_ready;
  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr;
  logic [MEMORY_WIDTH-1:0]      memory_data;

  logic                         output_valid;
  logic                         output_ready;
  logic [MEMORY_WIDTH-1:0]      output_instruction;
  logic [PC_WIDTH-1:0]          output_pc;
  logic [CC_ID_BITS-1:0]        output_cc_id;

  logic [NCC-1:0]               elaborating_chars;
  logic                         running;

  modport slave (
    input  input_pc_valid, input_pc, input_cc_id, flush_cc,
    input  memory_ready, memory_data, output_ready,
    output input_pc_ready, memory_valid, memory_addr,
    output output_valid, output_instruction, output_pc, output_cc_id,
    output elaborating_chars, running
  );

  modport master (
    output input_pc_valid, input_pc, input_cc_id, flush_cc,
    output memory_ready, memory_data, output_ready,
    input  input_pc_ready, memory_valid, memory_addr,
    input  output_valid, output_instruction, output_pc, output_cc_id,
    input  elaborating_chars, running
  );
endinterface

// File: rtl/regex_fetch_unit.sv
// Queues per-context PC fetch requests and issues one memory read at a time; 4 cycles accept-to-output.
// input_pc_ready is low only when the queue is full; memory and output stalls hold state; flushes kill work.
module regex_fetch_unit #(
  parameter int PC_WIDTH              = 9,
  parameter int CC_ID_BITS            = 2,
  parameter int MEMORY_WIDTH          = 16,
  parameter int MEMORY_ADDR_WIDTH     = 11,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input logic               clk,
  input logic               rst,
  regex_fetch_unit_if.slave bus
);
  localparam int NCC = 2**CC_ID_BITS;
  localparam int PW  = FIFO_WIDTH_POWER_OF_2;
  localparam int D   = 2**PW;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(D);

  if (MEMORY_ADDR_WIDTH < PC_WIDTH) begin : g_addr_width_check
    $error("regex_fetch_unit: MEMORY_ADDR_WIDTH must be >= PC_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, HOLD} state_t;

  state_t                state;
  logic [PC_WIDTH-1:0]   q_pc [D];
  logic [CC_ID_BITS-1:0] q_cc [D];
  logic [D-1:0]          q_live;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  push;
  logic                  pop;
  logic                  head_live;
  logic [PC_WIDTH-1:0]   cur_pc;
  logic [CC_ID_BITS-1:0] cur_cc;
  logic                  cur_live;
  logic [NCC-1:0]        elab;

  assign bus.input_pc_ready = (count != FULL_CNT);
  assign push      = bus.input_pc_valid && bus.input_pc_ready;
  assign pop       = (state == IDLE) && (count != '0);
  // A head flushed on the very edge it is popped is treated as dead.
  assign head_live = q_live[rd_ptr] && !bus.flush_cc[q_cc[rd_ptr]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (bus.flush_cc[q_cc[i]]) q_live[i] <= 1'b0;
      end
      // Popped slots are cleared so q_live alone marks queued live work.
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        q_pc[wr_ptr]   <= bus.input_pc;
        q_cc[wr_ptr]   <= bus.input_cc_id;
        q_live[wr_ptr] <= !bus.flush_cc[bus.input_cc_id];
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= IDLE;
      cur_pc                 <= '0;
      cur_cc                 <= '0;
      cur_live               <= 1'b0;
      bus.memory_valid       <= 1'b0;
      bus.memory_addr        <= '0;
      bus.output_valid       <= 1'b0;
      bus.output_instruction <= {MEMORY_WIDTH{1'b0}};
      bus.output_pc          <= '0;
      bus.output_cc_id       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && head_live) begin
            state            <= REQ;
            cur_pc           <= q_pc[rd_ptr];
            cur_cc           <= q_cc[rd_ptr];
            cur_live         <= 1'b1;
            bus.memory_valid <= 1'b1;
            bus.memory_addr  <= MEMORY_ADDR_WIDTH'(q_pc[rd_ptr]);
          end
        end
        REQ: begin
          // The read stays posted even when flushed; the result is dropped later.
          if (bus.flush_cc[cur_cc]) cur_live <= 1'b0;
          if (bus.memory_ready) begin
            bus.memory_valid <= 1'b0;
            state            <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (cur_live && !bus.flush_cc[cur_cc]) begin
            bus.output_instruction <= bus.memory_data;
            bus.output_pc          <= cur_pc;
            bus.output_cc_id       <= cur_cc;
            bus.output_valid       <= 1'b1;
            state                  <= HOLD;
          end else begin
            cur_live <= 1'b0;
            state    <= IDLE;
          end
        end
        HOLD: begin
          if (bus.output_ready || bus.flush_cc[cur_cc]) begin
            bus.output_valid <= 1'b0;
            cur_live         <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    elab = '0;
    for (int i = 0; i < D; i++) begin
      if (q_live[i]) elab[q_cc[i]] = 1'b1;
    end
    if (state != IDLE && cur_live) elab[cur_cc] = 1'b1;
  end

  assign bus.elaborating_chars = elab;
  assign bus.running           = (count != '0) || (state != IDLE);
endmodule

// File: tb/tb_regex_fetch_unit.sv
// Directed bench for regex_fetch_unit: reset, latency, memory stall, fill/drain, queued and in-flight flush, reset in HOLD.
module tb_regex_fetch_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] out_q [$];
  logic [31:0] req_q [$];
  logic [10:0] mem_addr_s;

  regex_fetch_unit_if bus ();

  regex_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [10:0] a);
    return (a == 11'd220) ? 16'h1A0B : {5'h15, a};
  endfunction

  // Memory: data appears one cycle after the accepting edge.
  always @(posedge clk) begin
    if (bus.memory_valid && bus.memory_ready) begin
      req_q.push_back(32'(bus.memory_addr));
      mem_addr_s = bus.memory_addr;
      #1 bus.memory_data = mem_fn(mem_addr_s);
    end
  end

  always @(posedge clk) begin
    if (rst && bus.output_valid && bus.output_ready) out_q.push_back(32'(bus.output_pc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.running && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.running), 32'h0);
  endtask

  task automatic push(input logic [8:0] pc, input logic [1:0] cc);
    bus.input_pc_valid = 1'b1;
    bus.input_pc       = pc;
    bus.input_cc_id    = cc;
    tick();
    bus.input_pc_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp3 [3];
    checks   = 0;
    failures = 0;
    rst                = 1'b0;
    bus.input_pc_valid = 1'b0;
    bus.input_pc       = '0;
    bus.input_cc_id    = '0;
    bus.flush_cc       = '0;
    bus.memory_ready   = 1'b0;
    bus.output_ready   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_in_rdy",  32'(bus.input_pc_ready), 32'h1);
    chk("rst_mem_vld", 32'(bus.memory_valid), 32'h0);
    chk("rst_mem_adr", 32'(bus.memory_addr), 32'h0);
    chk("rst_out_vld", 32'(bus.output_valid), 32'h0);
    chk("rst_instr",   32'(bus.output_instruction), 32'h0);
    chk("rst_out_pc",  32'(bus.output_pc), 32'h0);
    chk("rst_out_cc",  32'(bus.output_cc_id), 32'h0);
    chk("rst_elab",    32'(bus.elaborating_chars), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);

    // Single fetch latency
    rst              = 1'b1;
    bus.memory_ready = 1'b1;
    push(9'd220, 2'd2);
    chk("t1_elab",     32'(bus.elaborating_chars), 32'h4);
    chk("t1_mem_vld",  32'(bus.memory_valid), 32'h0);
    chk("t1_running",  32'(bus.running), 32'h1);
    tick();
    chk("t2_mem_vld",  32'(bus.memory_valid), 32'h1);
    chk("t2_mem_adr",  32'(bus.memory_addr), 32'd220);
    tick();
    chk("t3_mem_vld",  32'(bus.memory_valid), 32'h0);
    chk("t3_out_vld",  32'(bus.output_valid), 32'h0);
    tick();
    chk("t4_out_vld",  32'(bus.output_valid), 32'h1);
    chk("t4_instr",    32'(bus.output_instruction), 32'h1A0B);
    chk("t4_out_pc",   32'(bus.output_pc), 32'd220);
    chk("t4_out_cc",   32'(bus.output_cc_id), 32'd2);
    chk("t4_elab",     32'(bus.elaborating_chars), 32'h4);
    bus.output_ready = 1'b1;
    tick();
    bus.output_ready = 1'b0;
    chk("t5_out_vld",  32'(bus.output_valid), 32'h0);
    chk("t5_running",  32'(bus.running), 32'h0);
    chk("t5_elab",     32'(bus.elaborating_chars), 32'h0);

    // Memory backpressure for 5 cycles
    bus.memory_ready = 1'b0;
    push(9'd100, 2'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_vld", 32'(bus.memory_valid), 32'h1);
      chk("bp_mem_adr", 32'(bus.memory_addr), 32'd100);
      tick();
    end
    bus.memory_ready = 1'b1;
    tick();
    chk("bp_wait_vld", 32'(bus.memory_valid), 32'h0);
    tick();
    chk("bp_out_vld",  32'(bus.output_valid), 32'h1);
    chk("bp_instr",    32'(bus.output_instruction), 32'hA864);
    chk("bp_out_cc",   32'(bus.output_cc_id), 32'd1);
    bus.output_ready = 1'b1;
    tick();
    bus.output_ready = 1'b0;
    chk("bp_running",  32'(bus.running), 32'h0);

    // Fill D+1 with output stalled, then drain in order
    out_q.delete();
    for (int i = 0; i < 5; i++) begin
      chk("fill_rdy", 32'(bus.input_pc_ready), 32'h1);
      push(9'(10 + i), 2'd3);
    end
    chk("fill_full",    32'(bus.input_pc_ready), 32'h0);
    chk("fill_out_vld", 32'(bus.output_valid), 32'h1);
    chk("fill_out_pc",  32'(bus.output_pc), 32'd10);
    chk("fill_instr",   32'(bus.output_instruction), 32'hA80A);
    chk("fill_elab",    32'(bus.elaborating_chars), 32'h8);
    bus.output_ready = 1'b1;
    wait_idle("fill_drain_idle");
    chk("fill_n", 32'(out_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("fill_order", (i < out_q.size()) ? out_q[i] : 32'hFFFF_FFFF, 32'(10 + i));
    end

    // Flush queued entries of context 0
    bus.output_ready = 1'b0;
    out_q.delete();
    push(9'd50, 2'd2);
    push(9'd1, 2'd0);
    push(9'd2, 2'd1);
    push(9'd3, 2'd0);
    push(9'd4, 2'd1);
    chk("fq_full",   32'(bus.input_pc_ready), 32'h0);
    chk("fq_elab",   32'(bus.elaborating_chars), 32'h7);
    chk("fq_out_pc", 32'(bus.output_pc), 32'd50);
    bus.flush_cc = 4'b0001;
    tick();
    bus.flush_cc = 4'b0000;
    chk("fq_elab_after", 32'(bus.elaborating_chars), 32'h6);
    req_q.delete();
    bus.output_ready = 1'b1;
    wait_idle("fq_idle");
    exp3[0] = 32'd50;
    exp3[1] = 32'd2;
    exp3[2] = 32'd4;
    chk("fq_out_n", 32'(out_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("fq_out_order", (i < out_q.size()) ? out_q[i] : 32'hFFFF_FFFF, exp3[i]);
    end
    chk("fq_req_n", 32'(req_q.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk("fq_req_addr", (i < req_q.size()) ? req_q[i] : 32'hFFFF_FFFF, exp3[i+1]);
    end

    // Flush the in-flight context during WAIT_DATA
    out_q.delete();
    bus.input_pc_valid = 1'b1;
    bus.input_pc       = 9'd30;
    bus.input_cc_id    = 2'd1;
    tick();
    bus.input_pc    = 9'd31;
    bus.input_cc_id = 2'd2;
    tick();
    bus.input_pc_valid = 1'b0;
    chk("fi_req_vld", 32'(bus.memory_valid), 32'h1);
    chk("fi_req_adr", 32'(bus.memory_addr), 32'd30);
    tick();
    chk("fi_wait_vld", 32'(bus.memory_valid), 32'h0);
    bus.flush_cc = 4'b0010;
    tick();
    bus.flush_cc = 4'b0000;
    chk("fi_out_vld", 32'(bus.output_valid), 32'h0);
    chk("fi_mem_vld", 32'(bus.memory_valid), 32'h0);
    chk("fi_elab",    32'(bus.elaborating_chars), 32'h4);
    chk("fi_running", 32'(bus.running), 32'h1);
    tick();
    chk("fi_next_vld", 32'(bus.memory_valid), 32'h1);
    chk("fi_next_adr", 32'(bus.memory_addr), 32'd31);
    wait_idle("fi_idle");
    chk("fi_out_n", 32'(out_q.size()), 32'd1);
    chk("fi_out_pc", (out_q.size() > 0) ? out_q[0] : 32'hFFFF_FFFF, 32'd31);

    // Reset while holding an output with more work queued
    bus.output_ready = 1'b0;
    push(9'd77, 2'd3);
    push(9'd78, 2'd0);
    tick();
    tick();
    chk("rh_out_vld", 32'(bus.output_valid), 32'h1);
    chk("rh_out_pc",  32'(bus.output_pc), 32'd77);
    rst = 1'b0;
    tick();
    chk("rh2_out_vld", 32'(bus.output_valid), 32'h0);
    chk("rh2_running", 32'(bus.running), 32'h0);
    chk("rh2_in_rdy",  32'(bus.input_pc_ready), 32'h1);
    chk("rh2_elab",    32'(bus.elaborating_chars), 32'h0);
    chk("rh2_out_pc",  32'(bus.output_pc), 32'h0);
    rst = 1'b1;
    tick();
    tick();
    chk("rh3_running", 32'(bus.running), 32'h0);
    chk("rh3_mem_vld", 32'(bus.memory_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
